// File: rtl/rf_op_sequencer.sv
// Purpose : sequences ADD/SUB/AND/LDI on a single-read-port register file (read A, read B, compute, write back)
//           and keeps registered carry/zero flags.
// Latency : ALU ops write at acceptance edge +3 with done in the following cycle; LDI writes at acceptance edge +1.
// Backpr. : ready is high only in IDLE; start while busy is dropped (not queued).
// Ports   : clk/rst_b (sync active-low); command start/op/src_a/src_b/dst/imm; status ready/done/carry/zero;
//           register file read (rf_rd_addr -> rf_rd_data) and write (rf_wr_e/rf_wr_addr/rf_wr_data) pins.
module rf_op_sequencer #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [AW-1:0] src_a,
    input  logic [AW-1:0] src_b,
    input  logic [AW-1:0] dst,
    input  logic [W-1:0]  imm,
    output logic          ready,
    output logic          done,
    output logic          carry,
    output logic          zero,
    output logic [AW-1:0] rf_rd_addr,
    input  logic [W-1:0]  rf_rd_data,
    output logic          rf_wr_e,
    output logic [AW-1:0] rf_wr_addr,
    output logic [W-1:0]  rf_wr_data
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_LDI = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]    op_q;
    logic [AW-1:0] src_a_q;
    logic [AW-1:0] src_b_q;
    logic [AW-1:0] dst_q;
    logic [W-1:0]  imm_q;
    logic [W-1:0]  opa_q;
    logic [W-1:0]  opb_q;

    logic [W-1:0]  result;
    logic          result_c;
    logic [W:0]    arith_ext;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: LDI needs no operands so it skips both read states
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (op == OP_LDI) ? S_WB : S_RD_A;
            S_RD_A:  state_nxt = S_RD_B;
            S_RD_B:  state_nxt = S_WB;
            S_WB:    state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready      = 1'b0;
        done       = 1'b0;
        rf_rd_addr = '0;
        rf_wr_e    = 1'b0;
        rf_wr_addr = '0;
        rf_wr_data = '0;
        case (state)
            S_IDLE: ready = 1'b1;
            S_RD_A: rf_rd_addr = src_a_q;
            S_RD_B: rf_rd_addr = src_b_q;
            S_WB: begin
                rf_wr_e    = 1'b1;
                rf_wr_addr = dst_q;
                rf_wr_data = result;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Result and carry/borrow from the captured operands. The subtraction is
    // done one bit wider so the top bit is the borrow (set when opA < opB).
    always_comb begin
        arith_ext = '0;
        result    = '0;
        result_c  = 1'b0;
        case (op_q)
            OP_ADD: begin
                arith_ext = {1'b0, opa_q} + {1'b0, opb_q};
                result    = arith_ext[W-1:0];
                result_c  = arith_ext[W];
            end
            OP_SUB: begin
                arith_ext = {1'b0, opa_q} - {1'b0, opb_q};
                result    = arith_ext[W-1:0];
                result_c  = arith_ext[W];
            end
            OP_AND: result = opa_q & opb_q;
            default: result = imm_q;
        endcase
    end

    // Command latch, operand capture and flags. Operands are captured before
    // the write-back, so aliased src/dst always see pre-operation values.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            op_q    <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            imm_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                op_q    <= op;
                src_a_q <= src_a;
                src_b_q <= src_b;
                dst_q   <= dst;
                imm_q   <= imm;
            end
            if (state == S_RD_A) opa_q <= rf_rd_data;
            if (state == S_RD_B) opb_q <= rf_rd_data;
            if (state == S_WB) begin
                carry <= result_c;
                zero  <= (result == '0);
            end
        end
    end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Purpose : self-checking bench for rf_op_sequencer with an attached 4x8 register file.
// Latency : n/a (bench).
// Backpr. : n/a (bench).
module tb_rf_op_sequencer;

    localparam int W  = 8;
    localparam int AW = 2;
    localparam logic [1:0] ADD    = 2'b00;
    localparam logic [1:0] SUB    = 2'b01;
    localparam logic [1:0] AND_OP = 2'b10;
    localparam logic [1:0] LDI    = 2'b11;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          start;
    logic [1:0]    op;
    logic [AW-1:0] src_a, src_b, dst;
    logic [W-1:0]  imm;
    logic          ready, done, carry, zero;
    logic [AW-1:0] rf_rd_addr;
    logic [W-1:0]  rf_rd_data;
    logic          rf_wr_e;
    logic [AW-1:0] rf_wr_addr;
    logic [W-1:0]  rf_wr_data;

    // Register file attached to the sequencer
    logic [W-1:0] rf [4];
    int wr_total = 0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [W-1:0] exp_rf [4];
    logic [W-1:0] exp_res;
    logic         exp_c = 1'b0;
    logic         exp_z = 1'b0;

    // Observations of the last command
    int           obs_wcyc, obs_wcnt, obs_dcyc, obs_dcnt;
    logic [AW-1:0] obs_waddr, obs_rda, obs_rdb;
    logic [W-1:0] obs_wdata;

    rf_op_sequencer #(.W(W), .AW(AW)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .dst(dst), .imm(imm),
        .ready(ready), .done(done), .carry(carry), .zero(zero),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .rf_wr_e(rf_wr_e), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
    );

    always #5 clk = ~clk;

    assign rf_rd_data = rf[rf_rd_addr];

    always @(posedge clk) begin
        if (rf_wr_e) begin
            rf[rf_wr_addr] <= rf_wr_data;
            wr_total       <= wr_total + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Architectural effect of one command, from the operation definitions
    task automatic model_apply(input logic [1:0] o, input int a, input int b, input int d, input int im);
        int va, vb, r;
        logic c;
        va = int'(exp_rf[a]);
        vb = int'(exp_rf[b]);
        case (o)
            ADD:     begin r = va + vb; c = (r > 255); r = r % 256; end
            SUB:     begin c = (va < vb); r = (va - vb + 256) % 256; end
            AND_OP:  begin r = va & vb; c = 1'b0; end
            default: begin r = im % 256; c = 1'b0; end
        endcase
        exp_res   = 8'(r);
        exp_c     = c;
        exp_z     = (r == 0);
        exp_rf[d] = 8'(r);
    endtask

    // Issues one command at a negedge with the DUT idle and records what happens.
    // Cycle i is the cycle following acceptance edge + (i-1).
    task automatic do_cmd(input logic [1:0] o, input int a, input int b, input int d, input int im);
        start = 1'b1; op = o; src_a = 2'(a); src_b = 2'(b); dst = 2'(d); imm = 8'(im);
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); src_a = 2'($urandom); src_b = 2'($urandom);
        dst = 2'($urandom); imm = 8'($urandom);
        obs_wcyc = -1; obs_wcnt = 0; obs_dcyc = -1; obs_dcnt = 0;
        obs_waddr = '0; obs_wdata = '0; obs_rda = '0; obs_rdb = '0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (rf_wr_e) begin
                obs_wcnt++;
                if (obs_wcyc < 0) begin obs_wcyc = i; obs_waddr = rf_wr_addr; obs_wdata = rf_wr_data; end
            end
            if (done) begin
                obs_dcnt++;
                if (obs_dcyc < 0) obs_dcyc = i;
            end
            if (i == 1) obs_rda = rf_rd_addr;
            if (i == 2) obs_rdb = rf_rd_addr;
            if (obs_dcyc > 0 && ready) break;
        end
    endtask

    task automatic test_reset;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if ({carry, zero} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b%b expected 00", carry, zero); end
        n_checks++; if (rf_wr_e !== 1'b0) begin n_fail++; $display("FAIL reset_wr_e: got %b expected 0", rf_wr_e); end
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (wr_total !== 0) begin n_fail++; $display("FAIL reset_no_write: got %0d writes expected 0", wr_total); end
    endtask

    task automatic test_ldi;
        model_apply(LDI, 0, 0, 2, 8'h3C);
        do_cmd(LDI, 0, 0, 2, 8'h3C);
        n_checks++; if (obs_wcyc !== 1) begin n_fail++; $display("FAIL ldi_wr_cycle: got %0d expected 1", obs_wcyc); end
        n_checks++; if (obs_wcnt !== 1) begin n_fail++; $display("FAIL ldi_wr_count: got %0d expected 1", obs_wcnt); end
        n_checks++; if (obs_waddr !== 2'd2 || obs_wdata !== 8'h3C) begin n_fail++; $display("FAIL ldi_wr: got %0d/%h expected 2/3c", obs_waddr, obs_wdata); end
        n_checks++; if (obs_dcyc !== 2) begin n_fail++; $display("FAIL ldi_done_cycle: got %0d expected 2", obs_dcyc); end
        n_checks++; if (rf[2] !== 8'h3C) begin n_fail++; $display("FAIL ldi_r2: got %h expected 3c", rf[2]); end
        n_checks++; if (zero !== 1'b0 || carry !== 1'b0) begin n_fail++; $display("FAIL ldi_flags: got c%b z%b expected c0 z0", carry, zero); end
    endtask

    task automatic test_add_overflow;
        model_apply(LDI, 0, 0, 0, 8'hF0); do_cmd(LDI, 0, 0, 0, 8'hF0);
        model_apply(LDI, 0, 0, 1, 8'h20); do_cmd(LDI, 0, 0, 1, 8'h20);
        model_apply(ADD, 0, 1, 3, 0);
        do_cmd(ADD, 0, 1, 3, 0);
        n_checks++; if (obs_rda !== 2'd0 || obs_rdb !== 2'd1) begin n_fail++; $display("FAIL add_rd_addr: got %0d,%0d expected 0,1", obs_rda, obs_rdb); end
        n_checks++; if (obs_wcyc !== 3) begin n_fail++; $display("FAIL add_wr_cycle: got %0d expected 3", obs_wcyc); end
        n_checks++; if (obs_dcyc !== 4) begin n_fail++; $display("FAIL add_done_cycle: got %0d expected 4", obs_dcyc); end
        n_checks++; if (rf[3] !== 8'h10) begin n_fail++; $display("FAIL add_r3: got %h expected 10", rf[3]); end
        n_checks++; if (carry !== 1'b1 || zero !== 1'b0) begin n_fail++; $display("FAIL add_flags: got c%b z%b expected c1 z0", carry, zero); end
    endtask

    task automatic test_mid_reset;
        int w0;
        start = 1'b1; op = ADD; src_a = 2'd0; src_b = 2'd1; dst = 2'd2; imm = 8'h00;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (rf_rd_addr !== 2'd1) begin n_fail++; $display("FAIL midrst_in_rd_b: got %0d expected 1", rf_rd_addr); end
        w0 = wr_total;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        exp_c = 1'b0; exp_z = 1'b0;
        n_checks++; if (ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got ready%b done%b expected ready1 done0", ready, done); end
        n_checks++; if (carry !== 1'b0 || zero !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got c%b z%b expected c0 z0", carry, zero); end
        rst_b = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if (wr_total !== w0) begin n_fail++; $display("FAIL midrst_no_write: got %0d writes expected %0d", wr_total, w0); end
        for (int r = 0; r < 4; r++) begin
            n_checks++; if (rf[r] !== exp_rf[r]) begin n_fail++; $display("FAIL midrst_reg%0d: got %h expected %h", r, rf[r], exp_rf[r]); end
        end
    endtask

    task automatic test_sub;
        model_apply(SUB, 1, 1, 1, 0);
        do_cmd(SUB, 1, 1, 1, 0);
        n_checks++; if (rf[1] !== 8'h00) begin n_fail++; $display("FAIL sub_zero_r1: got %h expected 00", rf[1]); end
        n_checks++; if (zero !== 1'b1 || carry !== 1'b0) begin n_fail++; $display("FAIL sub_zero_flags: got c%b z%b expected c0 z1", carry, zero); end
        model_apply(SUB, 1, 0, 0, 0);
        do_cmd(SUB, 1, 0, 0, 0);
        n_checks++; if (rf[0] !== 8'h10) begin n_fail++; $display("FAIL sub_borrow_r0: got %h expected 10", rf[0]); end
        n_checks++; if (carry !== 1'b1 || zero !== 1'b0) begin n_fail++; $display("FAIL sub_borrow_flags: got c%b z%b expected c1 z0", carry, zero); end
    endtask

    task automatic test_alias;
        model_apply(ADD, 2, 2, 2, 0);
        do_cmd(ADD, 2, 2, 2, 0);
        n_checks++; if (obs_rda !== 2'd2 || obs_rdb !== 2'd2) begin n_fail++; $display("FAIL alias_rd_addr: got %0d,%0d expected 2,2", obs_rda, obs_rdb); end
        n_checks++; if (rf[2] !== 8'h78) begin n_fail++; $display("FAIL alias_r2: got %h expected 78", rf[2]); end
    endtask

    task automatic test_busy;
        int w0, wcyc, dcyc;
        logic [AW-1:0] wa;
        logic [W-1:0] wd;
        model_apply(AND_OP, 2, 3, 1, 0);
        start = 1'b1; op = AND_OP; src_a = 2'd2; src_b = 2'd3; dst = 2'd1; imm = 8'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        w0 = wr_total; wcyc = -1; dcyc = -1; wa = '0; wd = '0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (rf_wr_e && wcyc < 0) begin wcyc = i; wa = rf_wr_addr; wd = rf_wr_data; end
            if (done && dcyc < 0) dcyc = i;
            if (i == 1) begin start = 1'b1; op = LDI; dst = 2'd0; imm = 8'hFF; end
            if (i == 2) start = 1'b0;
            if (dcyc > 0 && ready) break;
        end
        n_checks++; if (wr_total - w0 !== 1) begin n_fail++; $display("FAIL busy_write_count: got %0d expected 1", wr_total - w0); end
        n_checks++; if (wcyc !== 3 || wa !== 2'd1 || wd !== exp_res) begin n_fail++; $display("FAIL busy_and_write: got c%0d a%0d d%h expected c3 a1 d%h", wcyc, wa, wd, exp_res); end
        n_checks++; if (rf[0] !== exp_rf[0]) begin n_fail++; $display("FAIL busy_r0_kept: got %h expected %h", rf[0], exp_rf[0]); end
        n_checks++; if (dcyc !== 4) begin n_fail++; $display("FAIL busy_done_cycle: got %0d expected 4", dcyc); end
    endtask

    task automatic test_back_to_back;
        int nw, dc0, dc1;
        int wc [2];
        logic [AW-1:0] wa [2];
        logic [W-1:0] wd [2];
        logic [W-1:0] res1;
        logic rdy5, rdy6;
        model_apply(SUB, 3, 2, 2, 0);
        res1 = exp_res;
        model_apply(LDI, 0, 0, 0, 8'hA5);
        start = 1'b1; op = SUB; src_a = 2'd3; src_b = 2'd2; dst = 2'd2; imm = 8'h00;
        @(posedge clk); #1;
        op = LDI; src_a = 2'd1; src_b = 2'd1; dst = 2'd0; imm = 8'hA5;
        nw = 0; dc0 = -1; dc1 = -1; rdy5 = 1'b0; rdy6 = 1'b1;
        wc[0] = -1; wc[1] = -1; wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (rf_wr_e && nw < 2) begin wc[nw] = i; wa[nw] = rf_wr_addr; wd[nw] = rf_wr_data; nw++; end
            if (done) begin if (dc0 < 0) dc0 = i; else if (dc1 < 0) dc1 = i; end
            if (i == 5) rdy5 = ready;
            if (i == 6) begin rdy6 = ready; start = 1'b0; end
            if (i >= 8 && ready) break;
        end
        n_checks++; if (wc[0] !== 3 || wa[0] !== 2'd2 || wd[0] !== res1) begin n_fail++; $display("FAIL b2b_first_write: got c%0d a%0d d%h expected c3 a2 d%h", wc[0], wa[0], wd[0], res1); end
        n_checks++; if (wc[1] !== 6 || wa[1] !== 2'd0 || wd[1] !== 8'hA5) begin n_fail++; $display("FAIL b2b_second_write: got c%0d a%0d d%h expected c6 a0 da5", wc[1], wa[1], wd[1]); end
        n_checks++; if (rdy5 !== 1'b1 || rdy6 !== 1'b0) begin n_fail++; $display("FAIL b2b_ready: got %b%b expected 10", rdy5, rdy6); end
        n_checks++; if (dc0 !== 4 || dc1 !== 7) begin n_fail++; $display("FAIL b2b_done: got %0d,%0d expected 4,7", dc0, dc1); end
        n_checks++; if (rf[2] !== exp_rf[2] || rf[0] !== exp_rf[0]) begin n_fail++; $display("FAIL b2b_regs: got %h,%h expected %h,%h", rf[2], rf[0], exp_rf[2], exp_rf[0]); end
        n_checks++; if (carry !== exp_c || zero !== exp_z) begin n_fail++; $display("FAIL b2b_flags: got c%b z%b expected c%b z%b", carry, zero, exp_c, exp_z); end
    endtask

    task automatic test_random;
        logic [1:0] o;
        int a, b, d, im, ewc;
        for (int n = 0; n < 40; n++) begin
            o  = 2'($urandom_range(0, 3));
            a  = $urandom_range(0, 3);
            b  = $urandom_range(0, 3);
            d  = $urandom_range(0, 3);
            im = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            model_apply(o, a, b, d, im);
            do_cmd(o, a, b, d, im);
            ewc = (o == LDI) ? 1 : 3;
            n_checks++; if (obs_wcyc !== ewc || obs_wcnt !== 1) begin n_fail++; $display("FAIL rand%0d_write_timing: got c%0d n%0d expected c%0d n1", n, obs_wcyc, obs_wcnt, ewc); end
            n_checks++; if (obs_waddr !== 2'(d) || obs_wdata !== exp_res) begin n_fail++; $display("FAIL rand%0d_write: got a%0d d%h expected a%0d d%h", n, obs_waddr, obs_wdata, d, exp_res); end
            n_checks++; if (obs_dcyc !== ewc + 1 || obs_dcnt !== 1) begin n_fail++; $display("FAIL rand%0d_done: got c%0d n%0d expected c%0d n1", n, obs_dcyc, obs_dcnt, ewc + 1); end
            n_checks++; if (carry !== exp_c || zero !== exp_z) begin n_fail++; $display("FAIL rand%0d_flags: got c%b z%b expected c%b z%b", n, carry, zero, exp_c, exp_z); end
            if (o != LDI) begin
                n_checks++; if (obs_rda !== 2'(a) || obs_rdb !== 2'(b)) begin n_fail++; $display("FAIL rand%0d_rd_addr: got %0d,%0d expected %0d,%0d", n, obs_rda, obs_rdb, a, b); end
            end
            for (int r = 0; r < 4; r++) begin
                n_checks++; if (rf[r] !== exp_rf[r]) begin n_fail++; $display("FAIL rand%0d_reg%0d: got %h expected %h", n, r, rf[r], exp_rf[r]); end
            end
        end
    endtask

    initial begin
        start = 1'b0; op = '0; src_a = '0; src_b = '0; dst = '0; imm = '0;
        test_reset;
        test_ldi;
        test_add_overflow;
        test_mid_reset;
        test_sub;
        test_alias;
        test_busy;
        test_back_to_back;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
